instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Sequential fetch stage directly upstream of the 128x8 RAM block.
- Drives the RAM's en/read/write/address controls and consumes its 8-bit read data.
- Assembles one- or two-byte instructions and hands them to the execute stage over a valid/ready handshake.
- Owns the program counter; supports jumps and halt requested by execute.

Parameters:
ADDR_WIDTH, 7, program counter / RAM address width (RAM depth 2^ADDR_WIDTH = 128)
DATA_WIDTH, 8, RAM word and opcode/operand width
RESET_PC, 0, program counter value loaded on reset

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  fetch enable; 0 stalls fetching in FETCH_OP
mem_en  output  1  RAM enable
mem_read  output  1  RAM read strobe
mem_write  output  1  RAM write strobe; constant 0
mem_address  output  ADDR_WIDTH  RAM address; always equals pc
mem_data  input  DATA_WIDTH  RAM read data; combinational, valid in the same cycle as en&read
instr_valid  output  1  opcode/operand hold a complete instruction
instr_ready  input  1  execute accepts the instruction
opcode  output  DATA_WIDTH  fetched opcode byte
operand  output  DATA_WIDTH  fetched operand byte; 0 for one-byte instructions
has_operand  output  1  opcode[DATA_WIDTH-1] of the held instruction
jump_en  input  1  load pc from jump_addr on acceptance
jump_addr  input  ADDR_WIDTH  jump target
halt  input  1  enter HALTED on acceptance
pc  output  ADDR_WIDTH  current program counter
halted  output  1  block in HALTED

Behaviour:
- Reset: takes effect at any clock edge with reset=1, in any state including mid-instruction. Next state is FETCH_OP.
- Register reset values: pc=RESET_PC; opcode=0; operand=0; has_operand=0; instr_valid=0; halted=0. Any partially fetched instruction is discarded.
- Memory outputs are combinational from state:
  - mem_en=mem_read=1 only in FETCH_OP with run=1, and in FETCH_ARG.
  - Otherwise mem_en=mem_read=0.
  - mem_write=0 always; mem_address=pc always.
- FETCH_OP:
  - run=0: no memory access; stay.
  - run=1: at the edge, opcode<=mem_data, has_operand<=mem_data[7], pc<=pc+1, operand<=0.
  - Next state is FETCH_ARG if mem_data[7]=1, else HOLD.
- FETCH_ARG: fetch ignores run. At the edge, operand<=mem_data, pc<=pc+1; next state is HOLD.
- HOLD:
  - instr_valid=1; opcode/operand/has_operand stable; no memory access.
  - Stays in HOLD until instr_ready=1; run is ignored in this state.
  - On the edge with instr_ready=1, priority is halt > jump_en > sequential:
    - halt=1: go to HALTED.
    - jump_en=1: pc<=jump_addr, go to FETCH_OP.
    - otherwise: go to FETCH_OP; pc already points at the next instruction.
  - instr_valid drops in the cycle after acceptance.
- jump_en and halt are ignored unless sampled in HOLD with instr_ready=1.
- HALTED: halted=1, instr_valid=0, no memory access, pc frozen. Exit only via reset.
- Latency, counted from the first FETCH_OP cycle with run=1:
  - one-byte instruction: instr_valid in cycle 2.
  - two-byte instruction: instr_valid in cycle 3.
  - Back-to-back one-byte instructions with instr_ready held at 1: one instruction every 2 cycles.
- pc arithmetic is modulo 2^ADDR_WIDTH: pc=127 increments to 0, including an operand fetch that wraps.
- instr_ready while instr_valid=0 has no effect.

Test Plan:
- Reset, then RAM[0]=0x05, RAM[1]=0x06, run=1, instr_ready=1 -> mem_address 0 then 1; instr_valid=1 with opcode=0x05, operand=0x00, has_operand=0 in cycle 2; opcode=0x06 in cycle 4; pc=2 after the second acceptance.
- RAM[0]=0x83, RAM[1]=0x2A -> two read cycles at addresses 0 and 1; instr_valid in cycle 3 with opcode=0x83, operand=0x2A, has_operand=1; pc=2.
- Hold instr_ready=0 for 5 cycles in HOLD -> instr_valid stays 1, outputs stable, mem_en=0; raise instr_ready -> next fetch starts in the following cycle.
- Accept with jump_en=1, jump_addr=0x40 -> the next mem_address is 0x40 with mem_en=1; a concurrent halt=1 instead -> halted=1, mem_en stays 0 until reset.
- pc=127 holding 0x81, RAM[0]=0x11 -> operand fetched from address 0, operand=0x11, pc=1.
- Assert reset during FETCH_ARG; separately, hold run=0 after reset -> reset: next cycle pc=0, instr_valid=0, opcode=0, state FETCH_OP. run=0: mem_en=0 and pc=0 held indefinitely.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches 1/2-byte instructions from RAM and hands them to execute
module instruction_fetch #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int RESET_PC = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  mem_en,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  has_operand,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);
  typedef enum logic [1:0] {FETCH_OP, FETCH_ARG, HOLD, HALTED} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] opcode_q, opcode_d, operand_q, operand_d;
  logic                  has_operand_q, has_operand_d, instr_valid_q, instr_valid_d, halted_q, halted_d;
  logic                  fetch, accept, two_byte;
  assign fetch       = (state_q == FETCH_OP && run) || state_q == FETCH_ARG;
  assign accept      = state_q == HOLD && instr_ready;
  assign two_byte    = mem_data[DATA_WIDTH-1];
  assign mem_en      = fetch;
  assign mem_read    = fetch;
  assign mem_write   = 1'b0;
  assign mem_address = pc_q;
  assign pc          = pc_q;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign has_operand = has_operand_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  // next-state: byte capture on fetch cycles, halt > jump > sequential on acceptance
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    opcode_d      = opcode_q;
    operand_d     = operand_q;
    has_operand_d = has_operand_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    if (state_q == FETCH_OP && run) begin
      opcode_d      = mem_data;
      operand_d     = '0;
      has_operand_d = two_byte;
      pc_d          = pc_q + ADDR_WIDTH'(1);
      state_d       = two_byte ? FETCH_ARG : HOLD;
      instr_valid_d = !two_byte;
    end else if (state_q == FETCH_ARG) begin
      operand_d     = mem_data;
      pc_d          = pc_q + ADDR_WIDTH'(1);
      state_d       = HOLD;
      instr_valid_d = 1'b1;
    end else if (accept) begin
      instr_valid_d = 1'b0;
      halted_d      = halt;
      state_d       = halt ? HALTED : FETCH_OP;
      pc_d          = (!halt && jump_en) ? jump_addr : pc_q;
    end
  end
  // state registers; reset discards any partially fetched instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH_OP;
      pc_q          <= ADDR_WIDTH'(RESET_PC);
      opcode_q      <= '0;
      operand_q     <= '0;
      has_operand_q <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      opcode_q      <= opcode_d;
      operand_q     <= operand_d;
      has_operand_q <= has_operand_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: vector table plus corner-case sequences with an instruction scoreboard
module tb_instruction_fetch;
  logic       clk = 1'b0;
  logic       reset, run, instr_ready, jump_en, halt;
  logic       mem_en, mem_read, mem_write, instr_valid, has_operand, halted;
  logic [6:0] mem_address, jump_addr, pc;
  logic [7:0] mem_data, opcode, operand;
  logic [7:0] ram [128];
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] opc;
    logic [7:0] opr;
    logic       has;
  } exp_t;
  typedef struct {
    logic [7:0] op;
    logic [7:0] arg;
    exp_t       exp;
    int         lat;
    logic [6:0] pc_after;
  } vec_t;
  exp_t sb[$];
  vec_t vecs[5];
  assign mem_data = ram[mem_address];
  always #5 clk = ~clk;
  instruction_fetch dut (
    .clk(clk), .reset(reset), .run(run), .mem_en(mem_en), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
    .operand(operand), .has_operand(has_operand), .jump_en(jump_en),
    .jump_addr(jump_addr), .halt(halt), .pc(pc), .halted(halted)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pop_check(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected instruction %0h", name, opcode);
    end else begin
      e = sb.pop_front();
      chk({name, ".opcode"}, opcode, e.opc);
      chk({name, ".operand"}, operand, e.opr);
      chk({name, ".has_operand"}, has_operand, e.has);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1; run = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; halt = 1'b0; jump_addr = '0;
    foreach (ram[i]) ram[i] = 8'h00;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask
  // run must already be 1 at the current negedge (cycle 1)
  task automatic wait_valid(input string name, output int cyc);
    cyc = 1;
    #1;
    while (!instr_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!instr_valid) chk({name, ".timeout"}, 0, 1);
  endtask
  initial begin
    int lat;
    vecs[0] = '{8'h05, 8'h06, '{8'h05, 8'h00, 1'b0}, 2, 7'd1};
    vecs[1] = '{8'h83, 8'h2A, '{8'h83, 8'h2A, 1'b1}, 3, 7'd2};
    vecs[2] = '{8'h7F, 8'hEE, '{8'h7F, 8'h00, 1'b0}, 2, 7'd1};
    vecs[3] = '{8'h80, 8'hFF, '{8'h80, 8'hFF, 1'b1}, 3, 7'd2};
    vecs[4] = '{8'h00, 8'h99, '{8'h00, 8'h00, 1'b0}, 2, 7'd1};
    // reset state, run=0 stall
    do_reset();
    chk("rst.pc", pc, 0);
    chk("rst.valid", instr_valid, 0);
    chk("rst.opcode", opcode, 0);
    chk("rst.halted", halted, 0);
    chk("rst.mem_write", mem_write, 0);
    repeat (4) @(negedge clk);
    chk("stall.mem_en", mem_en, 0);
    chk("stall.mem_read", mem_read, 0);
    chk("stall.pc", pc, 0);
    // vector table: single instruction latency and contents
    foreach (vecs[k]) begin
      do_reset();
      ram[0] = vecs[k].op;
      ram[1] = vecs[k].arg;
      sb.push_back(vecs[k].exp);
      run = 1'b1;
      #1;
      chk($sformatf("v%0d.mem_en", k), {mem_en, mem_read}, 2'b11);
      chk($sformatf("v%0d.addr", k), mem_address, 0);
      wait_valid($sformatf("v%0d", k), lat);
      chk($sformatf("v%0d.latency", k), lat, vecs[k].lat);
      chk($sformatf("v%0d.pc", k), pc, vecs[k].pc_after);
      chk($sformatf("v%0d.hold_mem_en", k), mem_en, 0);
      pop_check($sformatf("v%0d", k));
    end
    // back-to-back one-byte instructions with ready held high
    do_reset();
    ram[0] = 8'h05; ram[1] = 8'h06;
    sb.push_back('{8'h05, 8'h00, 1'b0});
    sb.push_back('{8'h06, 8'h00, 1'b0});
    run = 1'b1; instr_ready = 1'b1;
    #1;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("b2b.valid_c%0d", c), instr_valid, (c == 2 || c == 4) ? 1 : 0);
      if (c == 1 || c == 3) chk($sformatf("b2b.addr_c%0d", c), mem_address, (c == 1) ? 0 : 1);
      if (instr_valid) pop_check($sformatf("b2b.c%0d", c));
    end
    chk("b2b.pc", pc, 2);
    // stall in HOLD for 5 cycles, then release
    do_reset();
    ram[0] = 8'h83; ram[1] = 8'h2A;
    sb.push_back('{8'h83, 8'h2A, 1'b1});
    run = 1'b1;
    wait_valid("hold", lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold.valid", instr_valid, 1);
      chk("hold.outs", {opcode, operand, has_operand}, {8'h83, 8'h2A, 1'b1});
      chk("hold.mem_en", mem_en, 0);
    end
    pop_check("hold");
    instr_ready = 1'b1;
    @(negedge clk);
    chk("release.valid", instr_valid, 0);
    chk("release.mem_en", mem_en, 1);
    chk("release.addr", mem_address, 2);
    // jump_en ignored outside HOLD, taken on acceptance
    do_reset();
    ram[0] = 8'h05;
    sb.push_back('{8'h05, 8'h00, 1'b0});
    run = 1'b1; jump_en = 1'b1; jump_addr = 7'h22;
    wait_valid("jump", lat);
    chk("jump.ignored_pc", pc, 1);
    pop_check("jump");
    jump_addr = 7'h40; instr_ready = 1'b1;
    @(negedge clk);
    jump_en = 1'b0; instr_ready = 1'b0;
    chk("jump.addr", mem_address, 7'h40);
    chk("jump.mem_en", mem_en, 1);
    // halt wins over jump; stuck until reset
    do_reset();
    ram[0] = 8'h05;
    run = 1'b1;
    wait_valid("halt", lat);
    halt = 1'b1; jump_en = 1'b1; jump_addr = 7'h40; instr_ready = 1'b1;
    @(negedge clk);
    halt = 1'b0; jump_en = 1'b0;
    chk("halt.halted", halted, 1);
    chk("halt.valid", instr_valid, 0);
    repeat (3) @(negedge clk);
    chk("halt.mem_en", mem_en, 0);
    chk("halt.pc", pc, 1);
    chk("halt.still", halted, 1);
    do_reset();
    chk("halt.reset", halted, 0);
    // pc wrap during operand fetch
    do_reset();
    ram[0] = 8'h05;
    run = 1'b1;
    wait_valid("wrap0", lat);
    ram[127] = 8'h81; ram[0] = 8'h11;
    sb.push_back('{8'h81, 8'h11, 1'b1});
    jump_en = 1'b1; jump_addr = 7'd127; instr_ready = 1'b1;
    @(negedge clk);
    jump_en = 1'b0; instr_ready = 1'b0;
    wait_valid("wrap", lat);
    chk("wrap.latency", lat, 3);
    chk("wrap.pc", pc, 1);
    pop_check("wrap");
    // reset in the middle of FETCH_ARG
    do_reset();
    ram[0] = 8'h83; ram[1] = 8'h55;
    run = 1'b1;
    @(negedge clk);
    chk("midrst.in_arg", {mem_en, mem_address}, {1'b1, 7'd1});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
    chk("midrst.pc", pc, 0);
    chk("midrst.valid", instr_valid, 0);
    chk("midrst.regs", {opcode, operand, has_operand}, 17'h0);
    repeat (3) @(negedge clk);
    chk("midrst.stall", {mem_en, pc}, 8'h0);
    run = 1'b1;
    #1;
    chk("midrst.fetch_op", {mem_en, mem_address}, {1'b1, 7'd0});
    chk("sb.empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
